// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, fetches one word at a time over
// req/gnt/rvalid, and hands {pc, pc+4, instr} to decode through a one-entry output slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr,
    output logic        if_exc_adel
);

    // state | meaning
    // REQ   | PC is fetchable; request issued once the output slot can take the result
    // WAIT  | one request granted, response pending (kill_q drops it)
    // EXC   | misaligned-fetch exception loaded; idle until the next redirect
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_EXC  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_exc_q, out_exc_d;

    logic [31:0] target_pc;
    logic        pc_bad;
    logic        slot_free;
    logic        req;

    assign target_pc = CHECK_ALIGN ? redirect_pc : {redirect_pc[31:2], 2'b00};
    assign pc_bad    = CHECK_ALIGN && (pc_q[1:0] != 2'b00);
    assign slot_free = !out_valid_q || if_ready;
    // A bad PC is never put on the bus; it turns into an exception entry instead.
    assign req       = rst_n && (state_q == ST_REQ) && slot_free && !redirect_valid && !pc_bad;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_pc4_d   = out_pc4_q;
        out_instr_d = out_instr_q;
        out_exc_d   = out_exc_q;

        if (if_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (req && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_WAIT;
                end else if (pc_bad && slot_free && !redirect_valid) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = pc_q;
                    out_pc4_d   = pc_q + 32'd4;
                    out_instr_d = 32'h0;
                    out_exc_d   = 1'b1;
                    state_d     = ST_EXC;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect_valid) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = req_pc_q;
                        out_pc4_d   = req_pc_q + 32'd4;
                        out_instr_d = imem_rdata;
                        out_exc_d   = 1'b0;
                    end
                end
            end
            ST_EXC: begin
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Redirect overrides everything; a fetch still in flight afterwards must be dropped.
        if (redirect_valid) begin
            pc_d        = target_pc;
            out_valid_d = 1'b0;
            if (state_q == ST_EXC) begin
                state_d = ST_REQ;
            end
            kill_d = (state_d == ST_WAIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'h0;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_pc4_q   <= 32'h0;
            out_instr_q <= 32'h0;
            out_exc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_pc4_q   <= out_pc4_d;
            out_instr_q <= out_instr_d;
            out_exc_q   <= out_exc_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = req ? pc_q : 32'h0;
    assign if_valid    = out_valid_q;
    assign if_pc       = out_pc_q;
    assign if_pc4      = out_pc4_q;
    assign if_instr    = out_instr_q;
    assign if_exc_adel = out_exc_q;

endmodule
